// File: rtl/rec_ctrl.sv
// Record/playback transport controller and 2-cycle single-port SRAM access sequencer.
// Turns one-cycle ADC/DAC sample requests into SETUP/STROBE accesses and tracks addresses and length.
module rec_ctrl #(
  parameter int              ADDR_W   = 18,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 18'h3FFFF,
  parameter bit              LOOP     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic              wr_req,
  input  logic [15:0]       wr_data,
  input  logic              rd_req,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   len,
  output logic              overrun
);

  localparam logic [1:0] M_IDLE   = 2'b00;
  localparam logic [1:0] M_REC    = 2'b01;
  localparam logic [1:0] M_PLAY   = 2'b10;
  localparam logic [1:0] M_PAUSE  = 2'b11;
  localparam logic [1:0] A_IDLE   = 2'b00;
  localparam logic [1:0] A_SETUP  = 2'b01;
  localparam logic [1:0] A_STROBE = 2'b10;

  logic [1:0]        r_mode, r_acc, w_mode_nxt;
  logic              r_acc_wr, r_wpend, r_rpend, r_overrun, r_rd_valid;
  logic [ADDR_W-1:0] r_waddr, r_raddr, r_acc_addr;
  logic [ADDR_W:0]   r_len;
  logic [15:0]       r_wbuf, r_acc_data, r_rd_data;
  logic [2:0]        r_btn_prev;
  logic w_rec_e, w_play_e, w_stop_e;
  logic w_wr_done, w_rd_done, w_last, w_full, w_pb_end;
  logic w_start, w_mode_chg, w_wr_acc, w_rd_acc;

  assign w_rec_e   = record_btn & ~r_btn_prev[0];
  assign w_play_e  = play_btn   & ~r_btn_prev[1];
  assign w_stop_e  = stop_btn   & ~r_btn_prev[2];

  assign w_wr_done = (r_acc == A_STROBE) &&  r_acc_wr;
  assign w_rd_done = (r_acc == A_STROBE) && !r_acc_wr;
  assign w_last    = w_rd_done && ({1'b0, r_acc_addr} == (r_len - 1'b1));
  assign w_full    = w_wr_done && (r_acc_addr == MAX_ADDR) && (r_mode == M_REC);
  assign w_pb_end  = w_last && !LOOP && ((r_mode == M_PLAY) || (r_mode == M_PAUSE));

  assign w_start   = (r_acc == A_IDLE) && (r_wpend || r_rpend);
  assign w_wr_acc  = wr_req && (r_mode == M_REC);
  assign w_rd_acc  = rd_req && (r_mode == M_PLAY);

  // Stop outranks record, record outranks play; automatic end-of-memory/playback wins last.
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      M_IDLE: if (!w_stop_e) begin
        if (w_rec_e)                        w_mode_nxt = M_REC;
        else if (w_play_e && r_len != '0)   w_mode_nxt = M_PLAY;
      end
      M_REC:  if (w_stop_e || w_rec_e)      w_mode_nxt = M_IDLE;
      M_PLAY: if (w_stop_e)                 w_mode_nxt = M_IDLE;
              else if (w_play_e)            w_mode_nxt = M_PAUSE;
      default: if (w_stop_e)                w_mode_nxt = M_IDLE;
               else if (w_play_e)           w_mode_nxt = M_PLAY;
    endcase
    if (w_full || w_pb_end) w_mode_nxt = M_IDLE;
  end

  assign w_mode_chg = (w_mode_nxt != r_mode);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_btn_prev <= '0;
      r_mode     <= M_IDLE;
      r_acc      <= A_IDLE;
      r_acc_wr   <= 1'b0;
      r_acc_addr <= '0;
      r_acc_data <= '0;
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_len      <= '0;
      r_wbuf     <= '0;
      r_wpend    <= 1'b0;
      r_rpend    <= 1'b0;
      r_overrun  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_btn_prev <= {stop_btn, play_btn, record_btn};
      r_mode     <= w_mode_nxt;
      r_rd_valid <= 1'b0;

      case (r_acc)
        A_IDLE: if (w_start) begin
          r_acc      <= A_SETUP;
          r_acc_wr   <= r_wpend;
          r_acc_addr <= r_wpend ? r_waddr : r_raddr;
          r_acc_data <= r_wbuf;
        end
        A_SETUP: r_acc <= A_STROBE;
        default: r_acc <= A_IDLE;
      endcase

      if (w_wr_done) begin
        r_waddr <= r_acc_addr + 1'b1;
        r_len   <= r_len + 1'b1;
      end
      if (w_rd_done) begin
        r_rd_data  <= sram_rdata;
        r_rd_valid <= 1'b1;
        r_raddr    <= (LOOP && w_last) ? '0 : r_acc_addr + 1'b1;
      end
      // Entering a transport state restarts its counter even if an old access just finished.
      if (w_mode_chg && w_mode_nxt == M_REC) begin
        r_waddr <= '0;
        r_len   <= '0;
      end
      if (w_mode_chg && r_mode == M_IDLE && w_mode_nxt == M_PLAY) r_raddr <= '0;

      if (w_start &&  r_wpend) r_wpend <= 1'b0;
      if (w_start && !r_wpend) r_rpend <= 1'b0;
      if (w_wr_acc) begin
        if (r_wpend) r_overrun <= 1'b1;
        else begin
          r_wpend <= 1'b1;
          r_wbuf  <= wr_data;
        end
      end
      if (w_rd_acc) begin
        if (r_rpend) r_overrun <= 1'b1;
        else         r_rpend   <= 1'b1;
      end
      if (w_mode_chg) begin
        r_wpend <= 1'b0;
        r_rpend <= 1'b0;
      end
    end
  end

  assign sram_addr  = r_acc_addr;
  assign sram_wdata = r_acc_data;
  assign sram_we    = (r_acc == A_STROBE) && r_acc_wr;
  assign sram_oe    = (r_acc != A_IDLE) && !r_acc_wr;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign mode       = r_mode;
  assign len        = r_len;
  assign overrun    = r_overrun;

endmodule

// File: doc/rec_ctrl.md
Name: rec_ctrl

Overview:
Record/playback controller and single-port SRAM access sequencer for the audio recorder. It owns the transport state (idle/record/play/pause), the write and read address counters and the recorded length, and turns one-cycle sample requests from the ADC deserializer and DAC serializer into 2-cycle SRAM accesses. It sits between the debounced buttons, adc/dac blocks and the SRAM pin driver, and replaces their private address counters.

Parameters:
ADDR_W, 18, SRAM address width
MAX_ADDR, 18'h3FFFF, last usable SRAM word address
LOOP, 0, 1 = playback wraps to address 0 at end of recording; 0 = return to IDLE

Ports:
clk  in  1  system clock (12 MHz from PLL)
reset  in  1  synchronous reset, active-low
record_btn  in  1  debounced record button level
play_btn  in  1  debounced play/pause button level
stop_btn  in  1  debounced stop button level
wr_req  in  1  1-cycle pulse: ADC sample ready
wr_data  in  16  sample to store, valid with wr_req
rd_req  in  1  1-cycle pulse: DAC needs next sample
rd_data  out  16  sample returned to DAC
rd_valid  out  1  1-cycle pulse, rd_data valid
sram_addr  out  ADDR_W  SRAM word address
sram_wdata  out  16  SRAM write data
sram_rdata  in  16  SRAM read data
sram_we  out  1  write strobe, active-high
sram_oe  out  1  output enable, active-high
mode  out  2  00 IDLE, 01 RECORD, 10 PLAY, 11 PAUSE
len  out  ADDR_W+1  number of samples recorded
overrun  out  1  sticky: request lost while one already pending

Behaviour:
- Reset (reset==0 at clk edge): mode=IDLE, len=0, counters=0, all outputs 0, pending flags and overrun cleared; applies mid-access, access abandoned.
- Buttons: rising-edge detected against registered previous level; 1 cycle latency edge->state change. Simultaneous edges: stop > record > play.
- IDLE: record edge -> RECORD, waddr=0, len=0. play edge with len!=0 -> PLAY, raddr=0; with len==0 ignored.
- RECORD: record or stop edge -> IDLE, len keeps count written. play ignored.
- PLAY: play edge -> PAUSE; stop -> IDLE. PAUSE: play edge -> PLAY, raddr preserved; stop -> IDLE; rd_req ignored.
- Requests: wr_req honoured only in RECORD, rd_req only in PLAY; otherwise dropped, no overrun. Each accepted request sets a 1-deep pending flag; request arriving while its flag already set -> overrun=1 (sticky until reset), request dropped.
- Access FSM: A_IDLE -> A_SETUP -> A_STROBE -> A_IDLE. Starts the cycle after a pending flag is seen in A_IDLE; pending cleared on entry to A_SETUP.
- Write: SETUP drives sram_addr=waddr, sram_wdata=wr_data (captured at request); STROBE sram_we=1, same addr/data. End of STROBE: waddr++, len++.
- Read: sram_addr=raddr, sram_oe=1 in SETUP and STROBE; sram_rdata captured at end of STROBE; rd_data updated, rd_valid=1 next cycle only. raddr++ then.
- Request->rd_valid latency: 4 cycles from rd_req sampled (pending, SETUP, STROBE, valid).
- Full: write to MAX_ADDR completes, len=MAX_ADDR+1, mode -> IDLE automatically.
- End of playback: after read of raddr==len-1: LOOP=1 -> raddr=0, stay PLAY; LOOP=0 -> IDLE.
- Mode change during an access: in-flight access finishes (counters/len updated, rd_valid still issued); pending flags cleared on any mode change.
- sram_we/sram_oe never both 1; addr/data held stable whole access; outside access sram_we=sram_oe=0.

Test Plan:
- Reset low 2 cycles mid-write (sram_we=1) -> next cycle mode=00, len=0, sram_we=0, overrun=0.
- record edge, 3 wr_req pulses (0x1111,0x2222,0x3333) spaced 8 cycles, record edge -> writes at addr 0,1,2 with we high 1 cycle each, mode 00, len=3.
- play edge, rd_req every 8 cycles, LOOP=0 -> rd_data 0x1111,0x2222,0x3333 each 4 cycles after rd_req, mode returns 00 after third read; LOOP=1 -> fourth read returns 0x1111.
- Two wr_req 1 cycle apart while first still pending -> overrun=1, only first sample written, len=1.
- MAX_ADDR=3, record 5 requests -> 4 writes (addr 0..3), mode auto 00, len=4, fifth request dropped without overrun.
- Same-cycle stop and play edges in PLAY -> IDLE; play during PAUSE resumes at preserved raddr; play in IDLE with len=0 -> stays 00.
